// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor: {Bout, diff} = {1'b0,X} - {1'b0,Y} - Bin,
// evaluated one bit per clock, LSB first. It is the companion of the ripple
// adder, so a sum can be subtracted back to recover the original operand.
//
// Operands arrive over a valid/ready handshake (accepted only in IDLE). The
// result is presented over a second valid/ready handshake and is held stable
// for as long as the consumer applies back-pressure. One transaction is in
// flight at a time; the throughput is one result per WIDTH+2 cycles.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in_valid   X, Y, Bin valid
//   in_ready   block can accept operands (high only in IDLE)
//   X          minuend, WIDTH bits
//   Y          subtrahend, WIDTH bits
//   Bin        borrow-in
//   out_valid  diff / Bout valid (high only in DONE)
//   out_ready  consumer accepts the result
//   diff       X - Y - Bin, low WIDTH bits
//   Bout       borrow-out (1 iff X < Y + Bin)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             Bout
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d;       // minuend, shifted right each RUN cycle
  logic [WIDTH-1:0]   y_q, y_d;       // subtrahend, shifted right each RUN cycle
  logic [WIDTH-1:0]   res_q, res_d;   // difference bits, filled from the MSB side
  logic [WIDTH-1:0]   diff_q, diff_d; // result shown to the consumer
  logic               borrow_q, borrow_d;
  logic               bout_q, bout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Full-subtractor slice on the current LSB of the operand shift registers.
  logic x_bit, y_bit, d_bit, borrow_nxt, last_bit;

  assign x_bit      = x_q[0];
  assign y_bit      = y_q[0];
  assign d_bit      = x_bit ^ y_bit ^ borrow_q;
  assign borrow_nxt = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow_q);
  assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));

  // Handshake outputs come straight from the state register, so there is no
  // combinational path from any input to any output.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign Bout      = bout_q;

  // ---------------------------------------------------------------------------
  // Next-state and datapath decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold-value default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d      = X;
          y_d      = Y;
          borrow_d = Bin;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        x_d      = x_q >> 1;
        y_d      = y_q >> 1;
        res_d    = {d_bit, res_q[WIDTH-1:1]};
        borrow_d = borrow_nxt;
        cnt_d    = cnt_q + 1'b1;
        if (last_bit) begin
          // The visible result only moves here, on entry to DONE.
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bout_d  = borrow_nxt;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the working registers are cleared along with the visible ones;
      // they are only a few flops and this keeps a discarded transaction from
      // leaving stale bits behind.
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // decoded from the previous state, independent of statement order.
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed table of operand/result records for a WIDTH=4 instance, followed by
// hand-written sequences for back-pressure, reset during RUN, random operands
// checked against an integer model plus an add-back round trip, and a WIDTH=8
// instance for the all-borrow corner.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W  = 4;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic         in_valid, in_ready, out_valid, out_ready, bin, bout;
  logic [W-1:0] x, y, diff;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (x),
    .Y         (y),
    .Bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .Bout      (bout)
  );

  // WIDTH=8 instance
  logic          in_valid8, in_ready8, out_valid8, out_ready8, bin8, bout8;
  logic [W8-1:0] x8, y8, diff8;

  serial_subtractor #(.WIDTH(W8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .X         (x8),
    .Y         (y8),
    .Bin       (bin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .diff      (diff8),
    .Bout      (bout8)
  );

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid on the WIDTH=4 instance; returns cycles waited.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // Full transaction with out_ready high: checks latency, handshake timing and
  // returns the observed result.
  task automatic run_txn(input string tag, input logic [W-1:0] xi, input logic [W-1:0] yi,
                         input logic bi, output logic [W-1:0] d_o, output logic b_o);
    int lat;
    check({tag, " in_ready before accept"}, int'(in_ready), 1);
    x = xi; y = yi; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    x = '0; y = '0; bin = 1'b0;
    wait_out(lat);
    check({tag, " latency"}, lat, W);
    check({tag, " in_ready low while out_valid"}, int'(in_ready), 0);
    d_o = diff;
    b_o = bout;
    tick();
    check({tag, " out_valid drops after handshake"}, int'(out_valid), 0);
    check({tag, " in_ready back"}, int'(in_ready), 1);
  endtask

  initial begin
    vec_t         vecs[8];
    logic [W-1:0] d;
    logic         b;
    int           lat;

    vecs[0] = '{x: 4'd9,  y: 4'd3,  bin: 1'b0, diff: 4'd6,  bout: 1'b0};
    vecs[1] = '{x: 4'd3,  y: 4'd9,  bin: 1'b0, diff: 4'd10, bout: 1'b1};
    vecs[2] = '{x: 4'd0,  y: 4'd0,  bin: 1'b1, diff: 4'd15, bout: 1'b1};
    vecs[3] = '{x: 4'd15, y: 4'd15, bin: 1'b1, diff: 4'd15, bout: 1'b1};
    vecs[4] = '{x: 4'd15, y: 4'd0,  bin: 1'b0, diff: 4'd15, bout: 1'b0};
    vecs[5] = '{x: 4'd5,  y: 4'd4,  bin: 1'b1, diff: 4'd0,  bout: 1'b0};
    vecs[6] = '{x: 4'd4,  y: 4'd5,  bin: 1'b0, diff: 4'd15, bout: 1'b1};
    vecs[7] = '{x: 4'd10, y: 4'd6,  bin: 1'b1, diff: 4'd3,  bout: 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; bin = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; x8 = '0; y8 = '0; bin8 = 1'b0;

    // ---- Reset state
    tick();
    tick();
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset diff", int'(diff), 0);
    check("reset Bout", int'(bout), 0);
    rst_n = 1'b1;
    tick();
    check("idle in_ready", int'(in_ready), 1);

    // ---- Directed table
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].bin, d, b);
      check($sformatf("vec%0d diff", i), int'(d), int'(vecs[i].diff));
      check($sformatf("vec%0d Bout", i), int'(b), int'(vecs[i].bout));
      // Result stays on the outputs in IDLE until the next entry to DONE.
      check($sformatf("vec%0d diff held in IDLE", i), int'(diff), int'(vecs[i].diff));
    end

    // ---- Back-pressure: 12 - 5 - 1 = 6, no borrow
    x = 4'd12; y = 4'd5; bin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    check("bp latency", lat, W);
    x = 4'd1; y = 4'd1; bin = 1'b0; in_valid = 1'b1;  // must be ignored
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp out_valid c%0d", c), int'(out_valid), 1);
      check($sformatf("bp diff c%0d", c), int'(diff), 6);
      check($sformatf("bp Bout c%0d", c), int'(bout), 0);
      check($sformatf("bp in_ready c%0d", c), int'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp release out_valid", int'(out_valid), 0);
    check("bp release in_ready", int'(in_ready), 1);
    // The ignored 1-1 request must not have started a transaction.
    for (int c = 0; c < W + 2; c++) tick();
    check("bp no phantom result", int'(out_valid), 0);
    check("bp diff unchanged", int'(diff), 6);

    // ---- Reset during RUN
    x = 4'd7; y = 4'd2; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst-run in_ready", int'(in_ready), 1);
    check("rst-run out_valid", int'(out_valid), 0);
    check("rst-run diff", int'(diff), 0);
    check("rst-run Bout", int'(bout), 0);
    begin
      int seen = 0;
      for (int c = 0; c < W + 4; c++) begin
        tick();
        if (out_valid) seen++;
      end
      check("rst-run no result emitted", seen, 0);
    end
    run_txn("after-rst", 4'd8, 4'd8, 1'b0, d, b);
    check("after-rst diff", int'(d), 0);
    check("after-rst Bout", int'(b), 0);

    // ---- Random operands against an integer model, then add back
    for (int i = 0; i < 50; i++) begin
      logic [W-1:0] rx, ry;
      logic         rb;
      int           r, sum;
      rx = W'($urandom_range(0, 15));
      ry = W'($urandom_range(0, 15));
      rb = 1'($urandom_range(0, 1));
      r  = int'(rx) - int'(ry) - int'(rb);
      run_txn($sformatf("rnd%0d", i), rx, ry, rb, d, b);
      check($sformatf("rnd%0d diff", i), int'(d), r & 15);
      check($sformatf("rnd%0d Bout", i), int'(b), (r < 0) ? 1 : 0);
      sum = int'(d) + int'(ry) + int'(rb);
      check($sformatf("rnd%0d add-back X", i), sum & 15, int'(rx));
      check($sformatf("rnd%0d add-back carry", i), (sum >> 4) & 1, int'(b));
    end

    // ---- WIDTH=8: 0x00 - 0xFF - 1 = 0x00 with borrow
    x8 = 8'h00; y8 = 8'hFF; bin8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b1;
    check("w8 in_ready", int'(in_ready8), 1);
    tick();
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      tick();
      lat++;
    end
    check("w8 latency", lat, W8);
    check("w8 diff", int'(diff8), 0);
    check("w8 Bout", int'(bout8), 1);
    check("w8 add-back X", (int'(diff8) + int'(y8) + int'(bin8)) & 8'hFF, int'(x8));
    tick();
    check("w8 out_valid drops", int'(out_valid8), 0);
    check("w8 in_ready back", int'(in_ready8), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
